recfg_delay_len_ctrl: RTL

Upstream length sequencer for the reconfigurable delay chain. Accepts a requested delay length over a valid/ready handshake, clamps it to [MIN_LEN, MAX_LEN], and slews the chain's length input toward the target one step per enabled cycle, so the chain never jumps by more than one tap. It also tracks chain fill and flags when the chain output holds real data.

---
 rtl/recfg_delay_len_ctrl.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/recfg_delay_len_ctrl.sv
// ---------------------------------------------------------------------------
// recfg_delay_len_ctrl
//
// Length sequencer that sits in front of a reconfigurable delay chain.
// A requested length is accepted over a valid/ready handshake, clamped to
// [MIN_LEN, MAX_LEN], and the chain's length input is then slewed toward
// that target one tap per enabled cycle (with an optional STEP_GAP enabled
// cycles of dwell between steps), so the chain never sees a jump larger
// than one tap. A saturating fill counter tracks how many times the chain
// has been advanced, so that the controller can report when the chain
// output holds real data.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset (release is synchronous
//                   to the chain's own clock domain)
//   en         in   chain advance enable (the same strobe the chain sees)
//   req_valid  in   a new length request is present
//   req_len    in   requested length, LW bits, unclamped
//   req_ready  out  controller is idle and will accept a request
//   length     out  current length driven to the chain
//   busy       out  slewing toward the target
//   clamped    out  one-cycle pulse: the accepted request was out of range
//   primed     out  chain has been advanced at least `length` times
// ---------------------------------------------------------------------------
module recfg_delay_len_ctrl #(
  parameter int MAX_LEN  = 16,
  parameter int MIN_LEN  = 0,
  parameter int INIT_LEN = 0,
  parameter int STEP_GAP = 0,
  parameter int LW       = $clog2(MAX_LEN + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          req_valid,
  input  logic [LW-1:0] req_len,
  output logic          req_ready,
  output logic [LW-1:0] length,
  output logic          busy,
  output logic          clamped,
  output logic          primed
);

  localparam logic [LW-1:0] MAX_L  = LW'(MAX_LEN);
  localparam logic [LW-1:0] MIN_L  = LW'(MIN_LEN);
  localparam logic [LW-1:0] INIT_L = LW'(INIT_LEN);
  localparam logic [LW-1:0] ONE_L  = LW'(1);

  // Gap counter counts 0 .. STEP_GAP-1; keep at least one bit so the
  // declaration stays legal when no dwell is configured.
  localparam int            GW       = (STEP_GAP > 1) ? $clog2(STEP_GAP) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(STEP_GAP - 1);
  localparam logic [GW-1:0] ONE_G    = GW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t        state;
  logic [LW-1:0] target;
  logic [GW-1:0] gap_cnt;
  logic [LW-1:0] fill;

  logic          accept;
  logic [LW-1:0] req_clamped;
  logic          req_oor;
  logic [LW-1:0] next_len;

  // Range handling is plain unsigned LW-bit arithmetic. The lower bound is
  // written as MIN_L > v so that a zero MIN_LEN simply folds away.
  function automatic logic out_of_range(input logic [LW-1:0] v);
    return (v > MAX_L) || (MIN_L > v);
  endfunction

  function automatic logic [LW-1:0] clamp_len(input logic [LW-1:0] v);
    if (v > MAX_L) begin
      return MAX_L;
    end
    if (MIN_L > v) begin
      return MIN_L;
    end
    return v;
  endfunction

  assign req_ready   = (state == IDLE);
  assign busy        = (state != IDLE);
  assign accept      = req_valid && req_ready;
  assign req_clamped = clamp_len(req_len);
  assign req_oor     = out_of_range(req_len);

  // One tap toward the target. Only used in STEP, where length != target,
  // so the decrement can never underflow below MIN_LEN.
  always_comb begin
    next_len = length;
    if (target > length) begin
      next_len = length + ONE_L;
    end else begin
      next_len = length - ONE_L;
    end
  end

  // Fill has reached the current length; a length decrease can raise this
  // in the same cycle, an increase can drop it.
  assign primed = (fill >= length);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      length  <= INIT_L;
      target  <= INIT_L;
      gap_cnt <= '0;
      clamped <= 1'b0;
    end else begin
      // clamped is a single-cycle pulse tied to the accept edge.
      clamped <= accept && req_oor;

      case (state)
        IDLE: begin
          // Acceptance does not depend on en; the first step waits for the
          // next enabled edge.
          if (accept) begin
            target <= req_clamped;
            if (req_clamped != length) begin
              state <= STEP;
            end
          end
        end

        STEP: begin
          if (en) begin
            length <= next_len;
            if (next_len == target) begin
              state <= IDLE;
            end else if (STEP_GAP > 0) begin
              state   <= HOLD;
              gap_cnt <= '0;
            end
          end
        end

        HOLD: begin
          if (en) begin
            if (gap_cnt == GAP_LAST) begin
              state <= STEP;
            end else begin
              gap_cnt <= gap_cnt + ONE_G;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Fill counts chain advances and saturates at MAX_LEN; it is independent
  // of length changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill <= '0;
    end else if (en && (fill != MAX_L)) begin
      fill <= fill + ONE_L;
    end
  end

endmodule
